// File: rtl/cva6_ras_circ.sv
// Circular return-address stack for the frontend branch predictor.
// Arbitrary depth with modulo pointer wrap. On overflow the oldest entry is overwritten.
// A push and pop in the same cycle atomically replace the top entry.
// Optional feature macro: RAS_STATS_EN adds 16-bit saturating overflow/underflow event counters.
module cva6_ras_circ #(
  parameter int unsigned RAS_DEPTH = 2,
  parameter int unsigned VLEN      = 32,
  localparam int unsigned CNT_W    = $clog2(RAS_DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_bp_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [VLEN-1:0]  data_i,
  output logic [VLEN-1:0]  data_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] count_o,
  output logic             overflow_o,
  output logic             underflow_o,
  output logic [15:0]      ovf_cnt_o,
  output logic [15:0]      unf_cnt_o
);

  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  // Depth need not be a power of two, so wrap against the last index explicitly
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

  logic [VLEN-1:0]  mem_q [RAS_DEPTH];
  logic [PTR_W-1:0] tos_q, tos_d, tos_inc, tos_dec;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             mem_we;
  logic [PTR_W-1:0] mem_waddr;

  // Modulo-RAS_DEPTH neighbours of the top-of-stack pointer
  always_comb begin
    tos_inc = (tos_q == LAST_PTR) ? '0 : tos_q + PTR_W'(1);
    tos_dec = (tos_q == '0) ? LAST_PTR : tos_q - PTR_W'(1);
  end

  // Next-state decode; priority flush > push&pop > push > pop
  always_comb begin
    tos_d     = tos_q;
    cnt_d     = cnt_q;
    ovf_d     = 1'b0;
    unf_d     = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = tos_q;
    if (flush_bp_i) begin
      // Entries are kept; only the occupancy view is discarded
      tos_d = '0;
      cnt_d = '0;
    end else if (push_i && pop_i) begin
      // Replace top in place; an empty stack becomes one entry
      mem_we = 1'b1;
      if (cnt_q == '0) cnt_d = CNT_W'(1);
    end else if (push_i) begin
      tos_d     = tos_inc;
      mem_we    = 1'b1;
      mem_waddr = tos_inc;
      if (cnt_q == FULL_CNT) ovf_d = 1'b1;
      else                   cnt_d = cnt_q + CNT_W'(1);
    end else if (pop_i) begin
      if (cnt_q != '0) begin
        tos_d = tos_dec;
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        unf_d = 1'b1;
      end
    end
  end

  // Pointer, occupancy and event-pulse registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tos_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      tos_q <= tos_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Entry storage
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(RAS_DEPTH); i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(RAS_DEPTH); i++) begin
        if (mem_we && (mem_waddr == PTR_W'(i))) mem_q[i] <= data_i;
      end
    end
  end

  // Top-of-stack read; deliberately unmasked when empty (consumers qualify with valid_o)
  always_comb begin
    data_o = '0;
    for (int i = 0; i < int'(RAS_DEPTH); i++) begin
      if (tos_q == PTR_W'(i)) data_o = mem_q[i];
    end
  end

  assign valid_o     = (cnt_q != '0);
  assign count_o     = cnt_q;
  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;

`ifdef RAS_STATS_EN
  logic [15:0] ovf_cnt_q, unf_cnt_q;

  // Saturating event counters; cleared by reset only, flush leaves them alone
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovf_cnt_q <= '0;
      unf_cnt_q <= '0;
    end else begin
      if (ovf_d && (ovf_cnt_q != 16'hFFFF)) ovf_cnt_q <= ovf_cnt_q + 16'd1;
      if (unf_d && (unf_cnt_q != 16'hFFFF)) unf_cnt_q <= unf_cnt_q + 16'd1;
    end
  end

  assign ovf_cnt_o = ovf_cnt_q;
  assign unf_cnt_o = unf_cnt_q;
`else
  assign ovf_cnt_o = 16'h0;
  assign unf_cnt_o = 16'h0;
`endif

endmodule

// File: tb/tb_cva6_ras_circ.sv
// Bench for cva6_ras_circ: a depth-2 and a depth-3 instance share stimulus and are
// compared against a behavioural stack model (index 0 = depth 2, index 1 = depth 3).
module tb_cva6_ras_circ;

`ifdef RAS_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk, rst, flush, push, pop;
  logic [31:0] data;

  logic [31:0] o_data  [2];
  logic        o_valid [2];
  logic [1:0]  o_cnt   [2];
  logic        o_ovf   [2];
  logic        o_unf   [2];
  logic [15:0] o_ovc   [2];
  logic [15:0] o_unc   [2];

  int errors = 0;
  int checks = 0;

  cva6_ras_circ #(.RAS_DEPTH(2), .VLEN(32)) dut2 (
    .clk_i(clk), .rst_i(rst), .flush_bp_i(flush), .push_i(push), .pop_i(pop),
    .data_i(data), .data_o(o_data[0]), .valid_o(o_valid[0]), .count_o(o_cnt[0]),
    .overflow_o(o_ovf[0]), .underflow_o(o_unf[0]), .ovf_cnt_o(o_ovc[0]),
    .unf_cnt_o(o_unc[0])
  );

  cva6_ras_circ #(.RAS_DEPTH(3), .VLEN(32)) dut3 (
    .clk_i(clk), .rst_i(rst), .flush_bp_i(flush), .push_i(push), .pop_i(pop),
    .data_i(data), .data_o(o_data[1]), .valid_o(o_valid[1]), .count_o(o_cnt[1]),
    .overflow_o(o_ovf[1]), .underflow_o(o_unf[1]), .ovf_cnt_o(o_ovc[1]),
    .unf_cnt_o(o_unc[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: physical slots, top index, occupancy, pulses, event tallies
  int          depth [2] = '{2, 3};
  logic [31:0] m_mem [2][3];
  int          m_tos [2];
  int          m_cnt [2];
  bit          m_ovf [2];
  bit          m_unf [2];
  int          m_ovc [2];
  int          m_unc [2];

  function automatic void m_reset();
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 3; j++) m_mem[k][j] = '0;
      m_tos[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0; m_unf[k] = 0; m_ovc[k] = 0; m_unc[k] = 0;
    end
  endfunction

  function automatic void m_step(input int k, input logic f, input logic pu, input logic po,
                                 input logic [31:0] d);
    int dep = depth[k];
    m_ovf[k] = 0;
    m_unf[k] = 0;
    if (f) begin
      m_tos[k] = 0;
      m_cnt[k] = 0;
    end else if (pu && po) begin
      m_mem[k][m_tos[k]] = d;
      if (m_cnt[k] == 0) m_cnt[k] = 1;
    end else if (pu) begin
      m_tos[k] = (m_tos[k] + 1) % dep;
      m_mem[k][m_tos[k]] = d;
      if (m_cnt[k] < dep) m_cnt[k]++;
      else begin
        m_ovf[k] = 1;
        if (m_ovc[k] < 65535) m_ovc[k]++;
      end
    end else if (po) begin
      if (m_cnt[k] > 0) begin
        m_tos[k] = (m_tos[k] + dep - 1) % dep;
        m_cnt[k]--;
      end else begin
        m_unf[k] = 1;
        if (m_unc[k] < 65535) m_unc[k]++;
      end
    end
  endfunction

  function automatic int exp_ovc(input int k);
    return STATS ? m_ovc[k] : 0;
  endfunction

  function automatic int exp_unc(input int k);
    return STATS ? m_unc[k] : 0;
  endfunction

  // Apply one cycle of stimulus, advance the model, then settle 1 time unit past the edge
  task automatic step(input logic f, input logic pu, input logic po, input logic [31:0] d);
    flush = f; push = pu; pop = po; data = d;
    @(posedge clk);
    m_step(0, f, pu, po, d);
    m_step(1, f, pu, po, d);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_reset();
    step(1'b0, 1'b1, 1'b0, 32'h1234_5678);
    step(1'b0, 1'b1, 1'b0, 32'h9abc_def0);
    #3;
    rst = 1'b1;
    #1;
    m_reset();
    // Asynchronous: no clock edge has occurred since reset rose
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o_data[k] !== 32'h0 || o_valid[k] !== 1'b0 || o_cnt[k] !== 2'd0 ||
          o_ovf[k] !== 1'b0 || o_unf[k] !== 1'b0 || o_ovc[k] !== 16'h0 || o_unc[k] !== 16'h0) begin
        errors++;
        $display("FAIL reset_async dut%0d: got data=%h valid=%b cnt=%0d ovf=%b unf=%b want all 0",
                 k, o_data[k], o_valid[k], o_cnt[k], o_ovf[k], o_unf[k]);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      idle();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (o_data[k] !== 32'h0 || o_valid[k] !== 1'b0 || o_cnt[k] !== 2'd0 ||
            o_ovf[k] !== 1'b0 || o_unf[k] !== 1'b0) begin
          errors++;
          $display("FAIL reset_hold dut%0d: got data=%h valid=%b cnt=%0d want all 0",
                   k, o_data[k], o_valid[k], o_cnt[k]);
        end
      end
    end
  endtask

  task automatic test_push_pop();
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h8000_0010);
    step(1'b0, 1'b1, 1'b0, 32'h8000_0020);
    checks++;
    if (o_data[0] !== 32'h8000_0020 || o_cnt[0] !== 2'd2) begin
      errors++;
      $display("FAIL push2: got data=%h cnt=%0d want 80000020 2", o_data[0], o_cnt[0]);
    end
    step(1'b0, 1'b0, 1'b1, 32'h0);
    checks++;
    if (o_data[0] !== 32'h8000_0010 || o_cnt[0] !== 2'd1) begin
      errors++;
      $display("FAIL pop1: got data=%h cnt=%0d want 80000010 1", o_data[0], o_cnt[0]);
    end
    step(1'b0, 1'b0, 1'b1, 32'h0);
    checks++;
    if (o_valid[0] !== 1'b0 || o_cnt[0] !== 2'd0) begin
      errors++;
      $display("FAIL pop2: got valid=%b cnt=%0d want 0 0", o_valid[0], o_cnt[0]);
    end
  endtask

  task automatic test_overflow();
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h8000_0010);
    step(1'b0, 1'b1, 1'b0, 32'h8000_0020);
    checks++;
    if (o_ovf[0] !== 1'b0) begin
      errors++;
      $display("FAIL ovf_early: got ovf=%b want 0", o_ovf[0]);
    end
    step(1'b0, 1'b1, 1'b0, 32'h8000_0030);
    checks++;
    if (o_ovf[0] !== 1'b1 || o_cnt[0] !== 2'd2 || o_data[0] !== 32'h8000_0030) begin
      errors++;
      $display("FAIL ovf_pulse: got ovf=%b cnt=%0d data=%h want 1 2 80000030",
               o_ovf[0], o_cnt[0], o_data[0]);
    end
    step(1'b0, 1'b0, 1'b1, 32'h0);
    checks++;
    if (o_ovf[0] !== 1'b0 || o_data[0] !== 32'h8000_0020) begin
      errors++;
      $display("FAIL ovf_pop1: got ovf=%b data=%h want 0 80000020", o_ovf[0], o_data[0]);
    end
    step(1'b0, 1'b0, 1'b1, 32'h0);
    checks++;
    if (o_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL ovf_pop2: got valid=%b want 0", o_valid[0]);
    end
  endtask

  task automatic test_replace();
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h8000_0010);
    step(1'b0, 1'b1, 1'b1, 32'h8000_0040);
    checks++;
    if (o_data[0] !== 32'h8000_0040 || o_cnt[0] !== 2'd1 || o_ovf[0] !== 1'b0 ||
        o_unf[0] !== 1'b0) begin
      errors++;
      $display("FAIL replace: got data=%h cnt=%0d ovf=%b unf=%b want 80000040 1 0 0",
               o_data[0], o_cnt[0], o_ovf[0], o_unf[0]);
    end
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h8000_0050);
    checks++;
    if (o_cnt[0] !== 2'd1 || o_unf[0] !== 1'b0 || o_data[0] !== 32'h8000_0050) begin
      errors++;
      $display("FAIL replace_empty: got cnt=%0d unf=%b data=%h want 1 0 80000050",
               o_cnt[0], o_unf[0], o_data[0]);
    end
  endtask

  task automatic test_underflow_flush();
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h0);
    checks++;
    if (o_unf[0] !== 1'b1 || o_cnt[0] !== 2'd0) begin
      errors++;
      $display("FAIL unf_pulse: got unf=%b cnt=%0d want 1 0", o_unf[0], o_cnt[0]);
    end
    idle();
    checks++;
    if (o_unf[0] !== 1'b0) begin
      errors++;
      $display("FAIL unf_clear: got unf=%b want 0", o_unf[0]);
    end
    step(1'b0, 1'b1, 1'b0, 32'h8000_0060);
    step(1'b0, 1'b1, 1'b0, 32'h8000_0070);
    step(1'b1, 1'b1, 1'b0, 32'h8000_0080);
    checks++;
    if (o_cnt[0] !== 2'd0 || o_ovf[0] !== 1'b0 || o_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL flush_push: got cnt=%0d ovf=%b valid=%b want 0 0 0",
               o_cnt[0], o_ovf[0], o_valid[0]);
    end
  endtask

  task automatic test_depth3_stats();
    logic [31:0] v [5];
    int want_ovc, want_unc;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_reset();
    for (int i = 0; i < 5; i++) begin
      v[i] = 32'h8000_1000 + 32'(i * 16);
      step(1'b0, 1'b1, 1'b0, v[i]);
    end
    want_ovc = STATS ? 2 : 0;
    checks++;
    if (o_cnt[1] !== 2'd3 || o_data[1] !== v[4] || o_ovc[1] !== 16'(want_ovc)) begin
      errors++;
      $display("FAIL d3_push5: got cnt=%0d data=%h ovc=%0d want 3 %h %0d",
               o_cnt[1], o_data[1], o_ovc[1], v[4], want_ovc);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b1, 32'h0);
      checks++;
      if (o_cnt[1] !== 2'(m_cnt[1]) || o_data[1] !== m_mem[1][m_tos[1]]) begin
        errors++;
        $display("FAIL d3_pop%0d: got cnt=%0d data=%h want %0d %h",
                 i, o_cnt[1], o_data[1], m_cnt[1], m_mem[1][m_tos[1]]);
      end
    end
    want_unc = STATS ? 1 : 0;
    checks++;
    if (o_unf[1] !== 1'b1 || o_unc[1] !== 16'(want_unc)) begin
      errors++;
      $display("FAIL d3_unf: got unf=%b unc=%0d want 1 %0d", o_unf[1], o_unc[1], want_unc);
    end
    step(1'b1, 1'b0, 1'b0, 32'h0);
    checks++;
    if (o_ovc[1] !== 16'(want_ovc) || o_unc[1] !== 16'(want_unc)) begin
      errors++;
      $display("FAIL d3_flush_stats: got ovc=%0d unc=%0d want %0d %0d",
               o_ovc[1], o_unc[1], want_ovc, want_unc);
    end
  endtask

  task automatic test_random();
    logic f, pu, po;
    for (int c = 0; c < 600; c++) begin
      f  = ($urandom_range(0, 15) == 0);
      pu = $urandom_range(0, 1) == 1;
      po = $urandom_range(0, 1) == 1;
      step(f, pu, po, $urandom);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (o_data[k] !== m_mem[k][m_tos[k]] || o_valid[k] !== (m_cnt[k] != 0) ||
            o_cnt[k] !== 2'(m_cnt[k]) || o_ovf[k] !== m_ovf[k] || o_unf[k] !== m_unf[k] ||
            o_ovc[k] !== 16'(exp_ovc(k)) || o_unc[k] !== 16'(exp_unc(k))) begin
          errors++;
          $display("FAIL random c%0d dut%0d: got data=%h v=%b cnt=%0d ovf=%b unf=%b ovc=%0d unc=%0d want data=%h v=%b cnt=%0d ovf=%b unf=%b ovc=%0d unc=%0d",
                   c, k, o_data[k], o_valid[k], o_cnt[k], o_ovf[k], o_unf[k], o_ovc[k],
                   o_unc[k], m_mem[k][m_tos[k]], (m_cnt[k] != 0), m_cnt[k], m_ovf[k],
                   m_unf[k], exp_ovc(k), exp_unc(k));
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0; push = 1'b0; pop = 1'b0; data = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_push_pop();
    test_overflow();
    test_replace();
    test_underflow_flush();
    test_depth3_stats();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
